el2_dccm_port_arb: RTL and testbench
====================================

# el2_dccm_port_arb

Shares the single DCCM read/write port between the LSU and the DMA slave. It sits between those two requesters and the DCCM memory wrapper. The LSU has fixed priority, and a starvation counter guarantees DMA forward progress. An optional post-reset zero-fill sweep writes every DCCM word before any requester is admitted.

## Interface
Parameters:
- DCCM_BITS, 16, byte-address width of DCCM; word count = 2^(DCCM_BITS-2)
- DCCM_FDATA_WIDTH, 39, data+ECC width per word
- DMA_STARVE_MAX, 4, consecutive LSU-won conflicts after which DMA takes priority (1..15)

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; synchronous, active-low
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle when valid&ready
- lsu_req_write  in  1  1=write, 0=read
- lsu_req_addr  in  DCCM_BITS  byte address, word aligned
- lsu_req_wdata  in  DCCM_FDATA_WIDTH  write data with ECC
- dma_req_valid, dma_req_ready, dma_req_write, dma_req_addr, dma_req_wdata  same as LSU, for DMA
- lsu_rd_valid  out  1  rd_data belongs to LSU read accepted previous cycle
- dma_rd_valid  out  1  rd_data belongs to DMA read accepted previous cycle
- rd_data  out  DCCM_FDATA_WIDTH  equals dccm_rd_data
- dccm_wren  out  1  DCCM write strobe
- dccm_rden  out  1  DCCM read strobe
- dccm_addr  out  DCCM_BITS  DCCM address
- dccm_wr_data  out  DCCM_FDATA_WIDTH  DCCM write data
- dccm_rd_data  in  DCCM_FDATA_WIDTH  DCCM read data, valid 1 cycle after dccm_rden
- init_done  out  1  arbiter admitting requests

## Operation
- States: INIT (zero-fill sweep) and RUN. Reset enters INIT when the macro is defined, RUN otherwise.
- INIT behaviour:
  - Word counter starts at 0. Each cycle: dccm_wren=1, dccm_addr={counter,2'b00}, dccm_wr_data=0. Both readys are 0.
  - Counter increments by 1. After the write at counter = 2^(DCCM_BITS-2)-1, the next state is RUN.
- RUN grant rule: dma_prio = (starve_cnt == DMA_STARVE_MAX).
  - lsu_req_ready = !(dma_prio & dma_req_valid).
  - dma_req_ready = dma_prio | !lsu_req_valid.
  - Readys do not depend on the requester's own valid.
- Exactly one request is accepted per cycle. The accepted request drives dccm_* combinationally: wren = write, rden = !write, addr and wr_data from that requester.
- With no accept, dccm_wren=dccm_rden=0, dccm_addr=0, dccm_wr_data=0.
- starve_cnt (4 bits):
  - increments when dma_req_valid & !dma accepted & lsu accepted;
  - clears on DMA accept or when dma_req_valid=0;
  - saturates at DMA_STARVE_MAX.
- Read return: a registered 1-bit owner tag produces lsu_rd_valid or dma_rd_valid in the cycle after the accepting read. rd_data is wired to dccm_rd_data. A write accept produces no return.
- Back-to-back accepts every cycle are allowed, including a read followed by a write.

## Timing
- While rst_l=0: every output is 0, including the readys, dccm strobes, rd_valids and init_done. starve_cnt, counter and owner tags clear at the edge.
- Reset asserted mid-operation takes effect at the next edge. A read accepted in the cycle of that edge produces no rd_valid. With the macro defined, the sweep restarts from word 0.
- init_done is registered:
  - With the macro: it rises the cycle after the last INIT write, i.e. 2^(DCCM_BITS-2)+1 cycles after the first cycle with rst_l=1.
  - Without the macro: it rises 1 cycle after rst_l=1. Readys stay 0 until init_done=1.
- Request-to-DCCM strobe latency is 0 (combinational). Accept-to-rd_valid latency is exactly 1 cycle.

## Configuration
- RV_DCCM_ZERO_INIT_EN defined: INIT state, word counter and sweep are present. All DCCM words hold zero data with zero ECC before the first request is accepted.
- RV_DCCM_ZERO_INIT_EN undefined: no INIT state or counter. The block enters RUN after reset, and DCCM contents are unknown until written.

## Test plan
- Macro on, DCCM_BITS=6, release reset -> 16 consecutive writes to addresses 0x00,0x04..0x3C with data 0; readys 0 throughout; init_done=1 on cycle 17.
- RUN, LSU read at 0x10 alone -> dccm_rden=1, addr=0x10 same cycle; lsu_rd_valid=1 next cycle with rd_data = DCCM model value; dma_rd_valid=0.
- LSU and DMA both valid continuously, DMA_STARVE_MAX=4 -> LSU accepted 4 cycles, DMA accepted on cycle 5, starve_cnt back to 0, pattern repeats 4:1.
- DMA alone writes 0x20 then reads 0x20 back-to-back -> wren then rden on consecutive cycles; dma_rd_valid returns the written word.
- Reset asserted in the cycle an LSU read is accepted -> no lsu_rd_valid afterwards; with the macro on, the sweep restarts at address 0.
- Macro off -> init_done=1 and lsu_req_ready=1 one cycle after reset release; no DCCM writes without a request.

Source files
------------

// File: rtl/el2_dccm_port_arb_if.sv
// Request, read-return and DCCM-side signals of the DCCM port arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface el2_dccm_port_arb_if #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39
);
    logic                        lsu_req_valid;
    logic                        lsu_req_ready;
    logic                        lsu_req_write;
    logic [DCCM_BITS-1:0]        lsu_req_addr;
    logic [DCCM_FDATA_WIDTH-1:0] lsu_req_wdata;

    logic                        dma_req_valid;
    logic                        dma_req_ready;
    logic                        dma_req_write;
    logic [DCCM_BITS-1:0]        dma_req_addr;
    logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata;

    logic                        lsu_rd_valid;
    logic                        dma_rd_valid;
    logic [DCCM_FDATA_WIDTH-1:0] rd_data;

    logic                        dccm_wren;
    logic                        dccm_rden;
    logic [DCCM_BITS-1:0]        dccm_addr;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data;

    logic                        init_done;

    modport slave (
        input  lsu_req_valid, lsu_req_write, lsu_req_addr, lsu_req_wdata,
        input  dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata,
        input  dccm_rd_data,
        output lsu_req_ready, dma_req_ready,
        output lsu_rd_valid, dma_rd_valid, rd_data,
        output dccm_wren, dccm_rden, dccm_addr, dccm_wr_data,
        output init_done
    );

    modport master (
        output lsu_req_valid, lsu_req_write, lsu_req_addr, lsu_req_wdata,
        output dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata,
        output dccm_rd_data,
        input  lsu_req_ready, dma_req_ready,
        input  lsu_rd_valid, dma_rd_valid, rd_data,
        input  dccm_wren, dccm_rden, dccm_addr, dccm_wr_data,
        input  init_done
    );
endinterface

// File: rtl/el2_dccm_port_arb.sv
// LSU/DMA arbiter for the single DCCM port: fixed LSU priority with a DMA starvation guard.
// Define RV_DCCM_ZERO_INIT_EN to zero-fill every DCCM word after reset before admitting requests.
module el2_dccm_port_arb #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DMA_STARVE_MAX   = 4
) (
    input logic clk,
    input logic rst_l,
    el2_dccm_port_arb_if.slave bus
);
    localparam int          WORD_BITS  = DCCM_BITS - 2;
    localparam logic [3:0]  STARVE_MAX = 4'(DMA_STARVE_MAX);

    logic       init_done_q;
    logic [3:0] starve_cnt;
    logic       rd_pend_q;
    logic       rd_owner_q;

    logic run_en;
    logic dma_prio;
    logic lsu_ready;
    logic dma_ready;
    logic lsu_acc;
    logic dma_acc;
    logic sweep;

`ifdef RV_DCCM_ZERO_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t               state;
    logic [WORD_BITS-1:0] init_cnt;

    assign sweep = rst_l & (state == INIT);
`else
    assign sweep = 1'b0;
`endif

    // Outputs are forced low whenever reset is asserted, not only after the edge.
    assign run_en    = rst_l & init_done_q;
    assign dma_prio  = (starve_cnt == STARVE_MAX);
    assign lsu_ready = run_en & ~(dma_prio & bus.dma_req_valid);
    assign dma_ready = run_en & (dma_prio | ~bus.lsu_req_valid);
    assign lsu_acc   = bus.lsu_req_valid & lsu_ready;
    assign dma_acc   = bus.dma_req_valid & dma_ready;

    assign bus.lsu_req_ready = lsu_ready;
    assign bus.dma_req_ready = dma_ready;
    assign bus.init_done     = run_en;
    assign bus.lsu_rd_valid  = rst_l & rd_pend_q & ~rd_owner_q;
    assign bus.dma_rd_valid  = rst_l & rd_pend_q & rd_owner_q;
    assign bus.rd_data       = rst_l ? bus.dccm_rd_data : '0;

    always_comb begin
        bus.dccm_wren    = 1'b0;
        bus.dccm_rden    = 1'b0;
        bus.dccm_addr    = '0;
        bus.dccm_wr_data = '0;
`ifdef RV_DCCM_ZERO_INIT_EN
        if (sweep) begin
            bus.dccm_wren = 1'b1;
            bus.dccm_addr = {init_cnt, 2'b00};
        end else
`endif
        if (lsu_acc) begin
            bus.dccm_wren    = bus.lsu_req_write;
            bus.dccm_rden    = ~bus.lsu_req_write;
            bus.dccm_addr    = bus.lsu_req_addr;
            bus.dccm_wr_data = bus.lsu_req_wdata;
        end else if (dma_acc) begin
            bus.dccm_wren    = bus.dma_req_write;
            bus.dccm_rden    = ~bus.dma_req_write;
            bus.dccm_addr    = bus.dma_req_addr;
            bus.dccm_wr_data = bus.dma_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            init_done_q <= 1'b0;
            starve_cnt  <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
`ifdef RV_DCCM_ZERO_INIT_EN
            state       <= INIT;
            init_cnt    <= '0;
`endif
        end else begin
`ifdef RV_DCCM_ZERO_INIT_EN
            case (state)
                INIT: begin
                    init_cnt <= WORD_BITS'(init_cnt + 1'b1);
                    if (init_cnt == {WORD_BITS{1'b1}}) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN:     init_done_q <= 1'b1;
                default: state <= INIT;
            endcase
`else
            init_done_q <= 1'b1;
`endif
            // Owner tag: 0 = LSU, 1 = DMA; only meaningful while a read is pending.
            rd_pend_q  <= (lsu_acc & ~bus.lsu_req_write) | (dma_acc & ~bus.dma_req_write);
            rd_owner_q <= dma_acc;

            if (!bus.dma_req_valid || dma_acc) begin
                starve_cnt <= '0;
            end else if (lsu_acc && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    logic unused_sweep;
    assign unused_sweep = sweep;
endmodule

// File: tb/tb_el2_dccm_port_arb.sv
// Randomized self-checking bench for el2_dccm_port_arb against a cycle-level behavioural model.
// Works with RV_DCCM_ZERO_INIT_EN either defined or undefined.
module tb_el2_dccm_port_arb;
    localparam int AW    = 6;
    localparam int FW    = 39;
    localparam int SMAX  = 4;
    localparam int NW    = 1 << (AW - 2);
`ifdef RV_DCCM_ZERO_INIT_EN
    localparam int DONE_LAT = NW;
`else
    localparam int DONE_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_l = 1'b0;

    el2_dccm_port_arb_if #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(FW)) bus ();

    el2_dccm_port_arb #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(FW), .DMA_STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [FW-1:0] dccm_mem [NW];
    logic [FW-1:0] ref_mem  [NW];

    // Behavioural model state: cycles since reset release, lost conflicts, pending read.
    int            k       = 0;
    int            losses  = 0;
    int            pend    = 0;
    logic [FW-1:0] pend_data = '0;

    int            last_win;
    logic          last_done, last_wren, last_rden, last_lrv, last_drv;
    logic [AW-1:0] last_addr;
    logic [FW-1:0] last_rd_data;

    function automatic logic [FW-1:0] fillPattern(input int i);
        return {7'(i), 32'hA5A5_0000 | 32'(i)};
    endfunction

    // Memory behind the DCCM port, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.dccm_wren) dccm_mem[bus.dccm_addr[AW-1:2]] <= bus.dccm_wr_data;
        if (bus.dccm_rden) bus.dccm_rd_data <= dccm_mem[bus.dccm_addr[AW-1:2]];
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else checks_passed++;
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic lv, input logic lw, input logic [AW-1:0] la, input logic [FW-1:0] ld,
                                 input logic dv, input logic dw, input logic [AW-1:0] da, input logic [FW-1:0] dd);
        rst_l             = r;
        bus.lsu_req_valid = lv;
        bus.lsu_req_write = lw;
        bus.lsu_req_addr  = la;
        bus.lsu_req_wdata = ld;
        bus.dma_req_valid = dv;
        bus.dma_req_write = dw;
        bus.dma_req_addr  = da;
        bus.dma_req_wdata = dd;
    endtask

    // Compare every output against the model for this cycle, then advance the model at the edge.
    task automatic checkOutput();
        logic          lv, lw, dv, dw, sweeping, starving;
        logic [AW-1:0] la, da;
        logic [FW-1:0] ld, dd;
        logic          e_done, e_lr, e_dr, e_wren, e_rden;
        logic [AW-1:0] e_addr;
        logic [FW-1:0] e_wd;
        int            win;
        lv = bus.lsu_req_valid; lw = bus.lsu_req_write; la = bus.lsu_req_addr; ld = bus.lsu_req_wdata;
        dv = bus.dma_req_valid; dw = bus.dma_req_write; da = bus.dma_req_addr; dd = bus.dma_req_wdata;
        e_done = 0; e_lr = 0; e_dr = 0; e_wren = 0; e_rden = 0; e_addr = '0; e_wd = '0;
        win = 0; sweeping = 0;
        if (rst_l) begin
`ifdef RV_DCCM_ZERO_INIT_EN
            sweeping = (k < NW);
`endif
            e_done   = (k >= DONE_LAT);
            starving = (losses == SMAX);
            e_lr     = e_done && !(starving && dv);
            e_dr     = e_done && (starving || !lv);
            if (e_done) begin
                if (lv && dv) win = starving ? 2 : 1;
                else if (lv)  win = 1;
                else if (dv)  win = 2;
            end
            if (sweeping) begin
                e_wren = 1; e_addr = AW'(k * 4);
            end else if (win == 1) begin
                e_wren = lw; e_rden = !lw; e_addr = la; e_wd = ld;
            end else if (win == 2) begin
                e_wren = dw; e_rden = !dw; e_addr = da; e_wd = dd;
            end
        end
        cmp("init_done",     bus.init_done,     e_done);
        cmp("lsu_req_ready", bus.lsu_req_ready, e_lr);
        cmp("dma_req_ready", bus.dma_req_ready, e_dr);
        cmp("dccm_wren",     bus.dccm_wren,     e_wren);
        cmp("dccm_rden",     bus.dccm_rden,     e_rden);
        cmp("dccm_addr",     bus.dccm_addr,     e_addr);
        cmp("dccm_wr_data",  bus.dccm_wr_data,  e_wd);
        cmp("lsu_rd_valid",  bus.lsu_rd_valid,  rst_l && pend == 1);
        cmp("dma_rd_valid",  bus.dma_rd_valid,  rst_l && pend == 2);
        if (!rst_l)        cmp("rd_data_reset", bus.rd_data, '0);
        else if (pend != 0) cmp("rd_data", bus.rd_data, pend_data);

        last_win     = (lv && bus.lsu_req_ready) ? 1 : (dv && bus.dma_req_ready) ? 2 : 0;
        last_done    = bus.init_done;
        last_wren    = bus.dccm_wren;
        last_rden    = bus.dccm_rden;
        last_addr    = bus.dccm_addr;
        last_lrv     = bus.lsu_rd_valid;
        last_drv     = bus.dma_rd_valid;
        last_rd_data = bus.rd_data;

        @(posedge clk);
        if (!rst_l) begin
            k = 0; losses = 0; pend = 0;
        end else begin
            if (sweeping) ref_mem[k] = '0;
            pend = 0;
            if (win == 1) begin
                if (lw) ref_mem[la[AW-1:2]] = ld;
                else begin pend = 1; pend_data = ref_mem[la[AW-1:2]]; end
            end else if (win == 2) begin
                if (dw) ref_mem[da[AW-1:2]] = dd;
                else begin pend = 2; pend_data = ref_mem[da[AW-1:2]]; end
            end
            if (!dv || win == 2)               losses = 0;
            else if (win == 1 && losses < SMAX) losses++;
            if (k < 100000) k++;
        end
    endtask

    task automatic runCycle(input logic r,
                            input logic lv, input logic lw, input logic [AW-1:0] la, input logic [FW-1:0] ld,
                            input logic dv, input logic dw, input logic [AW-1:0] da, input logic [FW-1:0] dd);
        @(negedge clk);
        applyStimulus(r, lv, lw, la, ld, dv, dw, da, dd);
        #1;
        checkOutput();
    endtask

    task automatic idleCycle();
        runCycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic randomCycle(input logic r);
        logic [AW-1:0] la, da;
        la = {4'($urandom_range(0, NW - 1)), 2'b00};
        da = {4'($urandom_range(0, NW - 1)), 2'b00};
        runCycle(r, $urandom_range(0, 9) < 6, 1'($urandom), la, {7'($urandom), 32'($urandom)},
                    $urandom_range(0, 9) < 6, 1'($urandom), da, {7'($urandom), 32'($urandom)});
    endtask

    initial begin
        logic [9:0] pattern;
        for (int i = 0; i < NW; i++) begin
            dccm_mem[i] = fillPattern(i);
            ref_mem[i]  = fillPattern(i);
        end
        bus.dccm_rd_data = '0;
        applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0);

        $display("[TB] reset with requests pending");
        for (int i = 0; i < 3; i++) randomCycle(0);
        cmp("reset_ready_literal", last_win, 0);

        $display("[TB] release reset, wait for init_done");
        for (int i = 1; i <= DONE_LAT + 1; i++) begin
            runCycle(1, 1, 0, '0, '0, 0, 0, '0, '0);
`ifdef RV_DCCM_ZERO_INIT_EN
            if (i <= NW) cmp("sweep_addr_literal", last_addr, AW'((i - 1) * 4));
`else
            if (i == 1) cmp("no_write_literal", last_wren, 0);
`endif
            if (i == DONE_LAT)     cmp("init_done_low_literal", last_done, 0);
            if (i == DONE_LAT + 1) cmp("init_done_high_literal", last_done, 1);
        end
        idleCycle();

        $display("[TB] LSU read at 0x10");
        runCycle(1, 1, 0, 6'h10, '0, 0, 0, '0, '0);
        cmp("lsu_rd_strobe_literal", {last_rden, last_addr}, {1'b1, 6'h10});
        idleCycle();
        cmp("lsu_rd_valid_literal", {last_lrv, last_drv}, 2'b10);
`ifdef RV_DCCM_ZERO_INIT_EN
        cmp("lsu_rd_data_literal", last_rd_data, 39'h0);
`else
        cmp("lsu_rd_data_literal", last_rd_data, 39'h04_A5A5_0004);
`endif

        $display("[TB] LSU and DMA contending");
        for (int i = 0; i < 10; i++) begin
            runCycle(1, 1, 0, {4'(i), 2'b00}, '0, 1, 0, {4'(15 - i), 2'b00}, '0);
            pattern[i] = (last_win == 2);
        end
        cmp("starve_pattern_literal", pattern, 10'h210);
        idleCycle();

        $display("[TB] DMA write then read 0x20");
        runCycle(1, 0, 0, '0, '0, 1, 1, 6'h20, 39'h5A_1234_5678);
        cmp("dma_wren_literal", {last_wren, last_rden}, 2'b10);
        runCycle(1, 0, 0, '0, '0, 1, 0, 6'h20, '0);
        cmp("dma_rden_literal", {last_wren, last_rden}, 2'b01);
        idleCycle();
        cmp("dma_rd_valid_literal", {last_lrv, last_drv}, 2'b01);
        cmp("dma_rd_data_literal", last_rd_data, 39'h5A_1234_5678);

        $display("[TB] reset during LSU read");
        runCycle(1, 1, 0, 6'h08, '0, 0, 0, '0, '0);
        runCycle(0, 1, 0, 6'h0C, '0, 0, 0, '0, '0);
        cmp("reset_kills_rd_valid_literal", last_lrv, 0);
        idleCycle();
        cmp("no_rd_valid_after_reset_literal", last_lrv, 0);
`ifdef RV_DCCM_ZERO_INIT_EN
        cmp("sweep_restart_literal", {last_wren, last_addr}, {1'b1, 6'h00});
`endif
        for (int i = 0; i < DONE_LAT + 1; i++) idleCycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) randomCycle($urandom_range(0, 149) != 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
